// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: groups the two requester handshakes and the RAM
// port signals shared by the arbiter. The slave modport is the arbiter
// itself. The master modport is the environment: the client engines plus
// the RAM instance.
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    // requester 0
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;
    logic [DATA_W-1:0] rdata0;

    // requester 1
    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata1;

    // RAM write port A and read port B
    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, rvalid0, rdata0,
        input  req1, we1, addr1, wdata1,
        output gnt1, rvalid1, rdata1,
        output ram_wr_en, ram_wr_addr, ram_wr_data,
        output ram_rd_en, ram_rd_addr,
        input  ram_rd_data
    );

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, rvalid0, rdata0,
        output req1, we1, addr1, wdata1,
        input  gnt1, rvalid1, rdata1,
        input  ram_wr_en, ram_wr_addr, ram_wr_data,
        input  ram_rd_en, ram_rd_addr,
        output ram_rd_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one dual-port RAM (write port A, read port B)
// between two requesters. Writes and reads each have their own round-robin
// arbiter, so one write and one read can issue in the same cycle. Grants are
// combinational. Read data returns one cycle later to the requester that
// owned the read.
// Optional feature macro: RAM_ARB_RAW_FWD_EN. When it is defined, a read that
// hits the same address as a same-cycle write returns the new write data.
module ram_port_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_port_arbiter_if.slave  bus
);

    logic              wr_req0;
    logic              wr_req1;
    logic              rd_req0;
    logic              rd_req1;
    logic              wr_gnt0;
    logic              wr_gnt1;
    logic              rd_gnt0;
    logic              rd_gnt1;
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        rd_owner;
    logic [ADDR_W-1:0] wr_addr_mux;
    logic [DATA_W-1:0] wr_data_mux;
    logic [ADDR_W-1:0] rd_addr_mux;
    logic [DATA_W-1:0] ret_data;

    assign wr_req0 = bus.req0 &  bus.we0;
    assign wr_req1 = bus.req1 &  bus.we1;
    assign rd_req0 = bus.req0 & ~bus.we0;
    assign rd_req1 = bus.req1 & ~bus.we1;

    // Round-robin grants. Under contention the pointer picks the winner.
    // Everything is gated off while reset is asserted.
    always_comb begin
        wr_gnt0 = rst_n & wr_req0 & (~wr_req1 | ~wr_ptr);
        wr_gnt1 = rst_n & wr_req1 & (~wr_req0 |  wr_ptr);
        rd_gnt0 = rst_n & rd_req0 & (~rd_req1 | ~rd_ptr);
        rd_gnt1 = rst_n & rd_req1 & (~rd_req0 |  rd_ptr);
    end

    // Steer the granted requester's address and data onto the RAM ports.
    // With no grant, the ports are zero.
    always_comb begin
        wr_addr_mux = '0;
        wr_data_mux = '0;
        rd_addr_mux = '0;
        if (wr_gnt0) begin
            wr_addr_mux = bus.addr0;
            wr_data_mux = bus.wdata0;
        end else if (wr_gnt1) begin
            wr_addr_mux = bus.addr1;
            wr_data_mux = bus.wdata1;
        end
        if (rd_gnt0) begin
            rd_addr_mux = bus.addr0;
        end else if (rd_gnt1) begin
            rd_addr_mux = bus.addr1;
        end
    end

    assign bus.gnt0        = wr_gnt0 | rd_gnt0;
    assign bus.gnt1        = wr_gnt1 | rd_gnt1;
    assign bus.ram_wr_en   = wr_gnt0 | wr_gnt1;
    assign bus.ram_wr_addr = wr_addr_mux;
    assign bus.ram_wr_data = wr_data_mux;
    assign bus.ram_rd_en   = rd_gnt0 | rd_gnt1;
    assign bus.ram_rd_addr = rd_addr_mux;

    // Pointers pass priority to the losing requester after each contended
    // grant. The read owner remembers who should receive next cycle's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            rd_owner <= 2'b00;
        end else begin
            if (wr_req0 & wr_req1) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_req0 & rd_req1) begin
                rd_ptr <= ~rd_ptr;
            end
            rd_owner <= {rd_gnt1, rd_gnt0};
        end
    end

`ifdef RAM_ARB_RAW_FWD_EN
    logic              fwd_valid;
    logic [DATA_W-1:0] fwd_data;

    // Capture the write data when a read hits the same address in the same
    // cycle, because the RAM itself would return the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid <= 1'b0;
            fwd_data  <= '0;
        end else begin
            fwd_valid <= bus.ram_wr_en & bus.ram_rd_en &
                         (wr_addr_mux == rd_addr_mux);
            fwd_data  <= wr_data_mux;
        end
    end

    assign ret_data = fwd_valid ? fwd_data : bus.ram_rd_data;
`else
    assign ret_data = bus.ram_rd_data;
`endif

    assign bus.rvalid0 = rd_owner[0];
    assign bus.rvalid1 = rd_owner[1];
    assign bus.rdata0  = rd_owner[0] ? ret_data : '0;
    assign bus.rdata1  = rd_owner[1] ? ret_data : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios followed by a randomized phase.
// All outputs are checked against a transaction-level reference model.
// The bench also contains a behavioural RAM with a registered read port.
module tb_ram_port_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;
`ifdef RAM_ARB_RAW_FWD_EN
    localparam logic [7:0] RAW_EXPECT = 8'hFF;
`else
    localparam logic [7:0] RAW_EXPECT = 8'h01;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_compared   = 0;
    int n_mismatched = 0;

    // reference model state
    int         wr_turn;
    int         rd_turn;
    logic [7:0] ref_mem [16];
    logic [1:0] exp_rvalid;
    logic [7:0] exp_rdata0;
    logic [7:0] exp_rdata1;

    // random-phase pending transactions
    logic       p_v    [2];
    logic       p_we   [2];
    logic [3:0] p_addr [2];
    logic [7:0] p_data [2];

    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // behavioural RAM: write port A, registered read port B, read-old-data
    logic [DW-1:0] ram_mem [16] = '{default: '0};

    always @(posedge clk) begin
        if (bus.ram_wr_en) ram_mem[bus.ram_wr_addr] <= bus.ram_wr_data;
        if (bus.ram_rd_en) bus.ram_rd_data <= ram_mem[bus.ram_rd_addr];
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // one winner under contention, chosen by whose turn it is
    function automatic logic [1:0] arbitrate(input logic [1:0] reqs, input int turn);
        if (reqs == 2'b11) return (turn == 0) ? 2'b01 : 2'b10;
        return reqs;
    endfunction

    task automatic modelReset();
        wr_turn    = 0;
        rd_turn    = 0;
        exp_rvalid = 2'b00;
        exp_rdata0 = 8'h00;
        exp_rdata1 = 8'h00;
    endtask

    task automatic checkOutput();
        logic [1:0] wreq, rreq, wg, rg;
        logic [3:0] waddr, raddr;
        logic [7:0] wdata, val;
        wreq = {bus.req1 & bus.we1,  bus.req0 & bus.we0};
        rreq = {bus.req1 & ~bus.we1, bus.req0 & ~bus.we0};
        wg = rst_n ? arbitrate(wreq, wr_turn) : 2'b00;
        rg = rst_n ? arbitrate(rreq, rd_turn) : 2'b00;
        waddr = wg[0] ? bus.addr0  : (wg[1] ? bus.addr1  : 4'h0);
        wdata = wg[0] ? bus.wdata0 : (wg[1] ? bus.wdata1 : 8'h00);
        raddr = rg[0] ? bus.addr0  : (rg[1] ? bus.addr1  : 4'h0);

        compare("gnt0",        bus.gnt0,        wg[0] | rg[0]);
        compare("gnt1",        bus.gnt1,        wg[1] | rg[1]);
        compare("ram_wr_en",   bus.ram_wr_en,   |wg);
        compare("ram_wr_addr", bus.ram_wr_addr, waddr);
        compare("ram_wr_data", bus.ram_wr_data, wdata);
        compare("ram_rd_en",   bus.ram_rd_en,   |rg);
        compare("ram_rd_addr", bus.ram_rd_addr, raddr);
        compare("rvalid0",     bus.rvalid0,     exp_rvalid[0]);
        compare("rvalid1",     bus.rvalid1,     exp_rvalid[1]);
        compare("rdata0",      bus.rdata0,      exp_rdata0);
        compare("rdata1",      bus.rdata1,      exp_rdata1);

        if (rst_n) begin
            if (wreq == 2'b11) wr_turn = 1 - wr_turn;
            if (rreq == 2'b11) rd_turn = 1 - rd_turn;
            val = ref_mem[raddr];
`ifdef RAM_ARB_RAW_FWD_EN
            if ((|wg) && (|rg) && waddr == raddr) val = wdata;
`endif
            exp_rvalid = rg;
            exp_rdata0 = rg[0] ? val : 8'h00;
            exp_rdata1 = rg[1] ? val : 8'h00;
            if (|wg) ref_mem[waddr] = wdata;
        end
    endtask

    task automatic applyStimulus(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        @(negedge clk);
        bus.req0 = r0; bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
        bus.req1 = r1; bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
        #1;
        checkOutput();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        compare("reset_rvalid0", bus.rvalid0, 1'b0);
        compare("reset_gnt0",    bus.gnt0,    1'b0);
        rst_n = 1'b1;

        $display("[TB] write then read back by requester 0");
        applyStimulus(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
        compare("t1_wr_gnt0", bus.gnt0, 1'b1);
        applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
        compare("t1_rd_gnt0", bus.gnt0, 1'b1);
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        compare("t1_rvalid0", bus.rvalid0, 1'b1);
        compare("t1_rdata0",  bus.rdata0,  8'hA5);
        compare("t1_rvalid1", bus.rvalid1, 1'b0);

        $display("[TB] write contention");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 1, 4'd1, 8'h11, 1, 1, 4'd2, 8'h22);
            compare($sformatf("t2_gnt0_%0d", i), bus.gnt0, (i % 2 == 0));
            compare($sformatf("t2_gnt1_%0d", i), bus.gnt1, (i % 2 == 1));
        end

        $display("[TB] simultaneous write and read");
        applyStimulus(1, 1, 4'd5, 8'h3C, 1, 0, 4'd7, 8'h00);
        compare("t3_gnt0",   bus.gnt0,      1'b1);
        compare("t3_gnt1",   bus.gnt1,      1'b1);
        compare("t3_wr_en",  bus.ram_wr_en, 1'b1);
        compare("t3_rd_en",  bus.ram_rd_en, 1'b1);
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        compare("t3_rvalid1", bus.rvalid1, 1'b1);
        compare("t3_rdata1",  bus.rdata1,  8'h00);

        $display("[TB] read during write, same address");
        applyStimulus(1, 1, 4'd9, 8'h01, 0, 0, 4'd0, 8'h00);
        applyStimulus(1, 1, 4'd9, 8'hFF, 1, 0, 4'd9, 8'h00);
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        compare("t4_rvalid1", bus.rvalid1, 1'b1);
        compare("t4_rdata1",  bus.rdata1,  RAW_EXPECT);

        $display("[TB] continuous reads from both requesters");
        for (int i = 0; i < 7; i++) begin
            if (i < 6) applyStimulus(1, 0, 4'd3, 8'h00, 1, 0, 4'd5, 8'h00);
            else       applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
            if (i > 0) begin
                compare($sformatf("t5_rvalid0_%0d", i), bus.rvalid0, ((i - 1) % 2 == 0));
                compare($sformatf("t5_rvalid1_%0d", i), bus.rvalid1, ((i - 1) % 2 == 1));
                compare($sformatf("t5_rdata_%0d", i), bus.rdata0 | bus.rdata1,
                        ((i - 1) % 2 == 0) ? 8'hA5 : 8'h3C);
            end
        end

        $display("[TB] reset during pending read");
        applyStimulus(1, 0, 4'd3, 8'h00, 0, 0, 4'd0, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd4; bus.wdata0 = 8'h44;
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 4'd6; bus.wdata1 = 8'h66;
        #1;
        modelReset();
        compare("t6_rvalid0_rst", bus.rvalid0,   1'b0);
        compare("t6_rdata0_rst",  bus.rdata0,    8'h00);
        compare("t6_gnt0_rst",    bus.gnt0,      1'b0);
        compare("t6_gnt1_rst",    bus.gnt1,      1'b0);
        compare("t6_wr_en_rst",   bus.ram_wr_en, 1'b0);
        compare("t6_wr_addr_rst", bus.ram_wr_addr, 4'h0);
        @(negedge clk);
        bus.req0 = 0; bus.req1 = 0;
        rst_n = 1'b1;
        applyStimulus(1, 1, 4'd4, 8'h44, 1, 1, 4'd6, 8'h66);
        compare("t6_rvalid0_rel", bus.rvalid0, 1'b0);
        compare("t6_gnt0_first",  bus.gnt0,    1'b1);
        compare("t6_gnt1_first",  bus.gnt1,    1'b0);
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd6, 8'h66);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 2; k++) p_v[k] = 1'b0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p_v[k] && $urandom_range(0, 3) != 0) begin
                    p_v[k]    = 1'b1;
                    p_we[k]   = 1'($urandom_range(0, 1));
                    p_addr[k] = 4'($urandom_range(0, 15));
                    p_data[k] = 8'($urandom_range(0, 255));
                end
            end
            applyStimulus(p_v[0], p_we[0], p_addr[0], p_data[0],
                          p_v[1], p_we[1], p_addr[1], p_data[1]);
            if (bus.gnt0) p_v[0] = 1'b0;
            if (bus.gnt1) p_v[1] = 1'b0;
        end
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
